// File: rtl/lsu_dmem.sv
// lsu_dmem: load/store unit between the core execute/writeback path and the
// data-memory bus. Formats byte lanes, byte enables and load extension, runs a
// req/ack handshake with a bounded wait, and stalls the core until done.
// Optional build macro: LSU_MISALIGN_TRAP_EN (misaligned H/HU/W become error
// responses with no bus access; otherwise low offset bits are truncated).
module lsu_dmem #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state, state_nxt;
  logic [2:0]       funct3_q;
  logic [1:0]       lane_q;
  logic [CNT_W-1:0] cnt_q;

  logic        f3_legal;
  logic        misalign;
  logic        accept_ok;
  logic        accept_bad;
  logic        ack_hit;
  logic        tmo_hit;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [31:0] load_data;

  // Decode which funct3 codes are legal for the requested direction
  always_comb begin
    f3_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ~req_we;
      default:                f3_legal = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Halfwords need an even address, words need a word-aligned address
  always_comb begin
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
  end
`else
  assign misalign = 1'b0;
`endif

  assign accept_ok  = req_valid & f3_legal & ~misalign;
  assign accept_bad = req_valid & ~(f3_legal & ~misalign);
  assign ack_hit    = mem_req & mem_ack;
  assign tmo_hit    = (cnt_q == CNT_W'(TIMEOUT - 1));

  assign rsp_valid  = (state == S_RESP);
  assign stall      = req_valid & ~rsp_valid;

  // Place store data on the addressed lanes and build the byte enables
  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = req_wdata;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          wdata_fmt = {4{req_wdata[7:0]}};
          be_fmt    = 4'b0001 << req_addr[1:0];
        end
        2'b01: begin
          wdata_fmt = {2{req_wdata[15:0]}};
          be_fmt    = 4'b0011 << {req_addr[1], 1'b0};
        end
        default: begin
          wdata_fmt = req_wdata;
          be_fmt    = 4'b1111;
        end
      endcase
    end
  end

  // Pull the addressed byte/half out of the bus word and extend it
  always_comb begin
    byte_sh   = mem_rdata >> {lane_q, 3'b000};
    half_sh   = mem_rdata >> {lane_q[1], 4'b0000};
    load_data = 32'h0;
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b001:  load_data = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b010:  load_data = mem_rdata;
      3'b100:  load_data = {24'h0, byte_sh[7:0]};
      3'b101:  load_data = {16'h0, half_sh[15:0]};
      default: load_data = 32'h0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept_ok)       state_nxt = S_WAIT;
        else if (accept_bad) state_nxt = S_RESP;
      end
      S_WAIT:  if (ack_hit || tmo_hit) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus request, captured request fields, wait counter and response data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
      funct3_q  <= 3'b000;
      lane_q    <= 2'b00;
      cnt_q     <= '0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept_ok) begin
            mem_req   <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_be    <= be_fmt;
            mem_wdata <= wdata_fmt;
            funct3_q  <= req_funct3;
            lane_q    <= req_addr[1:0];
            cnt_q     <= '0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
          end else if (accept_bad) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b1;
          end
        end
        S_WAIT: begin
          // An ack on the last allowed cycle still completes normally
          if (ack_hit) begin
            mem_req   <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= mem_we ? 32'h0 : load_data;
          end else if (tmo_hit) begin
            mem_req   <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
